line_delay_taps: RTL and testbench



---
 rtl/line_delay_taps_if.sv | 40 ++++
 rtl/line_delay_taps.sv | 140 ++++++++++++++
 tb/tb_line_delay_taps.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/line_delay_taps_if.sv
// line_delay_taps_if: stream and control bundle for line_delay_taps.
//   master: drives enable, data_in, size, size_load; observes the outputs.
//   slave : the delay block itself.
//   enable     sample strobe
//   data_in    input pixel
//   size       requested line length (latched only on reset / size_load)
//   size_load  latch size and restart the delay line
//   out_valid  outputs updated this cycle
//   data_out   registered data_in (zero-delay tap)
//   taps_out   TAPS slices, slice k delayed by (k+1) lines
//   primed     every tap carries real data
//   size_err   (LINE_DELAY_STATUS_EN) latched size was clamped
//   overrun    (LINE_DELAY_STATUS_EN) sticky, a partially filled line was aborted
interface line_delay_taps_if #(
    parameter int DATA_WIDTH = 12,
    parameter int TAPS       = 2
);
    logic                       enable;
    logic [DATA_WIDTH-1:0]      data_in;
    logic [15:0]                size;
    logic                       size_load;
    logic                       out_valid;
    logic [DATA_WIDTH-1:0]      data_out;
    logic [TAPS*DATA_WIDTH-1:0] taps_out;
    logic                       primed;
`ifdef LINE_DELAY_STATUS_EN
    logic                       size_err;
    logic                       overrun;

    modport master (output enable, data_in, size, size_load,
                    input  out_valid, data_out, taps_out, primed, size_err, overrun);
    modport slave  (input  enable, data_in, size, size_load,
                    output out_valid, data_out, taps_out, primed, size_err, overrun);
`else
    modport master (output enable, data_in, size, size_load,
                    input  out_valid, data_out, taps_out, primed);
    modport slave  (input  enable, data_in, size, size_load,
                    output out_valid, data_out, taps_out, primed);
`endif
endinterface

// File: rtl/line_delay_taps.sv
// line_delay_taps: multi-tap programmable line delay for the pixel pipeline.
// Delivers the input stream together with TAPS copies, copy k delayed by
// (k+1)*size_eff accepted samples. All outputs appear one cycle after the
// accepted sample.
// Ports:
//   clk    system clock, rising edge
//   reset  synchronous, active-high
//   bus    line_delay_taps_if.slave (stream, size control, outputs)
// Optional: define LINE_DELAY_STATUS_EN to add size_err and overrun outputs.
module line_delay_taps #(
    parameter int DATA_WIDTH = 12,
    parameter int ADDR_WIDTH = 12,
    parameter int TAPS       = 2
) (
    input  logic clk,
    input  logic reset,
    line_delay_taps_if.slave bus
);
    localparam int MAX_SIZE = 1 << ADDR_WIDTH;
    localparam int SW       = ADDR_WIDTH + 1;
    localparam int FW       = 16 + $clog2(TAPS + 1);

    logic                             restart;
    logic                             accept;
    logic [SW-1:0]                    size_eff;
    logic [SW-1:0]                    size_clamp;
    logic                             size_one;
    logic [ADDR_WIDTH-1:0]            ptr;
    logic [ADDR_WIDTH-1:0]            ptr_nxt;
    logic [FW-1:0]                    fill;
    logic [FW-1:0]                    fill_max;
    logic [TAPS-1:0][FW-1:0]          thr;
    logic [TAPS-1:0]                  tap_ok;
    logic [TAPS-1:0][DATA_WIDTH-1:0]  rd;
    logic [TAPS-1:0][DATA_WIDTH-1:0]  taps;
    logic                             out_valid_q;
    logic [DATA_WIDTH-1:0]            data_out_q;
    logic                             primed_q;

    assign restart = reset | bus.size_load;
    assign accept  = bus.enable & ~restart;

    always_comb begin
        size_clamp = SW'(bus.size);
        if (bus.size == 16'd0)
            size_clamp = SW'(1);
        else if ({16'b0, bus.size} > 32'(MAX_SIZE))
            size_clamp = SW'(MAX_SIZE);
    end

    assign size_one = (size_eff == SW'(1));
    assign ptr_nxt  = ({1'b0, ptr} == size_eff - SW'(1)) ? '0 : ptr + 1'b1;
    assign fill_max = FW'(TAPS) * FW'(size_eff);

    always_ff @(posedge clk) begin
        if (restart) begin
            size_eff    <= size_clamp;
            ptr         <= '0;
            fill        <= '0;
            out_valid_q <= 1'b0;
            data_out_q  <= '0;
            tap_ok      <= '0;
            primed_q    <= 1'b0;
        end else begin
            out_valid_q <= bus.enable;
            if (bus.enable) begin
                data_out_q <= bus.data_in;
                ptr        <= ptr_nxt;
                if (fill != fill_max)
                    fill <= fill + 1'b1;
                // Gating uses the count of samples before this one, so a tap
                // opens on the first sample that has a full line behind it.
                for (int k = 0; k < TAPS; k++)
                    tap_ok[k] <= (fill >= thr[k]);
                primed_q <= (fill == fill_max);
            end
        end
    end

    for (genvar k = 0; k < TAPS; k++) begin : g_stage
        logic [DATA_WIDTH-1:0] mem [MAX_SIZE];
        logic [DATA_WIDTH-1:0] wdata;
        logic [ADDR_WIDTH-1:0] raddr;
        logic [DATA_WIDTH-1:0] rd_q;

        // Stage 0 reads its write address (read-before-write gives exactly
        // size_eff of delay). Later stages are fed from the previous stage's
        // read register, which is one accepted sample late, so they read one
        // slot ahead of the write pointer. At size_eff==1 that slot is the one
        // being written, so the incoming word is forwarded instead.
        if (k == 0) begin : g_first
            assign wdata = bus.data_in;
            assign raddr = ptr;
        end else begin : g_chain
            assign wdata = rd[k-1];
            assign raddr = ptr_nxt;
        end

        always_ff @(posedge clk) begin
            if (accept)
                mem[ptr] <= wdata;
        end

        always_ff @(posedge clk) begin
            if (restart)
                rd_q <= '0;
            else if (accept)
                rd_q <= (k != 0 && size_one) ? wdata : mem[raddr];
        end

        assign rd[k]   = rd_q;
        assign thr[k]  = FW'(k + 1) * FW'(size_eff);
        assign taps[k] = tap_ok[k] ? rd[k] : '0;
    end

    assign bus.out_valid = out_valid_q;
    assign bus.data_out  = data_out_q;
    assign bus.taps_out  = taps;
    assign bus.primed    = primed_q;

`ifdef LINE_DELAY_STATUS_EN
    logic size_oor;
    logic size_err_q;
    logic overrun_q;

    assign size_oor = (bus.size == 16'd0) || ({16'b0, bus.size} > 32'(MAX_SIZE));

    always_ff @(posedge clk) begin
        if (restart)
            size_err_q <= size_oor;
        if (reset)
            overrun_q <= 1'b0;
        else if (bus.size_load && !primed_q && fill != '0)
            overrun_q <= 1'b1;
    end

    assign bus.size_err = size_err_q;
    assign bus.overrun  = overrun_q;
`endif
endmodule

// File: tb/tb_line_delay_taps.sv
// tb_line_delay_taps: directed, table-driven check of line_delay_taps with
// DATA_WIDTH=12, ADDR_WIDTH=12, TAPS=2, plus a hand-written max-size run.
module tb_line_delay_taps;
    localparam int DW = 12;
    localparam int AW = 12;
    localparam int NT = 2;

    logic clk;
    logic reset;

    line_delay_taps_if #(.DATA_WIDTH(DW), .TAPS(NT)) bus ();

    line_delay_taps #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TAPS(NT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit rst;
        bit sl;
        bit en;
        int size;
        int din;
        int ev;
        int ed;
        int e0;
        int e1;
        int ep;
        int es;   // expected size_err, -1 = not checked
        int eo;   // expected overrun,  -1 = not checked
    } vec_t;

    vec_t vq[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic add(input bit rst, input bit sl, input bit en, input int size,
                       input int din, input int ev, input int ed, input int e0,
                       input int e1, input int ep, input int es, input int eo);
        vec_t v;
        v.rst = rst; v.sl = sl; v.en = en; v.size = size; v.din = din;
        v.ev = ev; v.ed = ed; v.e0 = e0; v.e1 = e1; v.ep = ep; v.es = es; v.eo = eo;
        vq.push_back(v);
    endtask

    // n accepted samples base+1..base+n at line length s
    task automatic plain(input int n, input int s, input int base, input int port_size,
                         input int eo);
        for (int j = 1; j <= n; j++)
            add(0, 0, 1, port_size, base + j, 1, base + j,
                (j > s) ? base + j - s : 0,
                (j > 2 * s) ? base + j - 2 * s : 0,
                (j > 2 * s) ? 1 : 0, -1, eo);
    endtask

    task automatic chk(input string name, input int idx, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s vec %0d: got %0d expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic drive(input bit rst, input bit sl, input bit en, input int size,
                         input int din);
        @(negedge clk);
        reset         = rst;
        bus.size_load = sl;
        bus.enable    = en;
        bus.size      = 16'(size);
        bus.data_in   = DW'(din);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0; bus.size_load = 1'b0; bus.enable = 1'b0;
        bus.size = 16'd0; bus.data_in = '0;

        // continuous stream, size 4
        add(1, 0, 0, 4, 0, 0, 0, 0, 0, 0, 0, 0);
        plain(20, 4, 0, 4, 0);

        // enable toggling 1010, outputs hold during gaps
        add(1, 0, 0, 4, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int j = 1; j <= 10; j++) begin
            add(0, 0, 1, 4, j, 1, j, (j > 4) ? j - 4 : 0, (j > 8) ? j - 8 : 0,
                (j > 8) ? 1 : 0, -1, 0);
            add(0, 0, 0, 4, 12'hABC, 0, j, (j > 4) ? j - 4 : 0, (j > 8) ? j - 8 : 0,
                (j > 8) ? 1 : 0, -1, 0);
        end

        // size 0 clamps to 1
        add(1, 0, 1, 0, 7, 0, 0, 0, 0, 0, 1, 0);
        plain(4, 1, 0, 0, 0);

        // mid-stream reload to size 3; later size port changes are ignored
        add(1, 0, 0, 4, 0, 0, 0, 0, 0, 0, 0, 0);
        plain(6, 4, 0, 4, 0);
        add(0, 1, 1, 3, 99, 0, 0, 0, 0, 0, 0, 1);
        plain(10, 3, 100, 7, 1);

        // reset together with enable and size_load, then clean restart
        add(1, 0, 0, 4, 0, 0, 0, 0, 0, 0, 0, -1);
        plain(5, 4, 0, 4, 0);
        add(1, 1, 1, 4, 55, 0, 0, 0, 0, 0, 0, 0);
        plain(10, 4, 0, 4, 0);

        foreach (vq[i]) begin
            drive(vq[i].rst, vq[i].sl, vq[i].en, vq[i].size, vq[i].din);
            chk("out_valid", i, int'(bus.out_valid), vq[i].ev);
            chk("data_out",  i, int'(bus.data_out), vq[i].ed);
            chk("tap0",      i, int'(bus.taps_out[DW-1:0]), vq[i].e0);
            chk("tap1",      i, int'(bus.taps_out[2*DW-1:DW]), vq[i].e1);
            chk("primed",    i, int'(bus.primed), vq[i].ep);
`ifdef LINE_DELAY_STATUS_EN
            if (vq[i].es >= 0) chk("size_err", i, int'(bus.size_err), vq[i].es);
            if (vq[i].eo >= 0) chk("overrun",  i, int'(bus.overrun), vq[i].eo);
`endif
        end

        // size 5000 clamps to the full 4096-entry line; pointer wraps at 4095
        drive(1, 0, 0, 5000, 0);
        chk("big_rst_primed", 0, int'(bus.primed), 0);
`ifdef LINE_DELAY_STATUS_EN
        chk("big_size_err", 0, int'(bus.size_err), 1);
`endif
        for (int i = 1; i <= 4098; i++) begin
            drive(0, 0, 1, 5000, i & 12'hFFF);
            if (i == 4096) begin
                chk("big_tap0_4096", i, int'(bus.taps_out[DW-1:0]), 0);
                chk("big_dout_4096", i, int'(bus.data_out), 0);
            end
            if (i == 4097) chk("big_tap0_4097", i, int'(bus.taps_out[DW-1:0]), 1);
            if (i == 4098) begin
                chk("big_tap0_4098", i, int'(bus.taps_out[DW-1:0]), 2);
                chk("big_tap1_4098", i, int'(bus.taps_out[2*DW-1:DW]), 0);
                chk("big_primed",    i, int'(bus.primed), 0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
